// File: rtl/hawk_axi_line_master.sv
// hawk_axi_line_master: turns single 64-byte line requests into 2-beat AXI4
// INCR bursts (256-bit data) and returns one response per request.
// Only one transaction is outstanding at a time, so responses stay in order.
// Optional macro HAWK_AXI_LINE_TIMEOUT_EN adds a response watchdog that
// aborts after TIMEOUT_CYCLES in BWAIT/R0/R1.
//
//   state | meaning
//   IDLE  | ready for a new request
//   AW    | write address phase
//   W0    | write data beat 0 (low half)
//   W1    | write data beat 1 (high half, wlast)
//   BWAIT | waiting for write response
//   AR    | read address phase
//   R0    | waiting for read beat 0
//   R1    | waiting for read beat 1
//   RSP   | response presented to the core
module hawk_axi_line_master #(
  parameter logic [5:0] AXI_ID = 6'd0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  // core request
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wr,
  input  logic [63:0]  req_addr,
  input  logic [511:0] req_wdata,
  input  logic [63:0]  req_be,
  // core response
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_wr,
  output logic         rsp_err,
  output logic [511:0] rsp_rdata,
  // write address channel
  output logic         awvalid,
  input  logic         awready,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic [5:0]   awid,
  // write data channel
  output logic         wvalid,
  input  logic         wready,
  output logic [255:0] wdata,
  output logic [31:0]  wstrb,
  output logic         wlast,
  // write response channel
  input  logic         bvalid,
  output logic         bready,
  input  logic [1:0]   bresp,
  input  logic [5:0]   bid,
  // read address channel
  output logic         arvalid,
  input  logic         arready,
  output logic [63:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic [5:0]   arid,
  // read data channel
  input  logic         rvalid,
  output logic         rready,
  input  logic [255:0] rdata,
  input  logic [1:0]   rresp,
  input  logic [5:0]   rid,
  input  logic         rlast
);

  typedef enum logic [3:0] {IDLE, AW, W0, W1, BWAIT, AR, R0, R1, RSP} stateT;

  stateT state, stateNext;

  logic [63:0]  addrCap;
  logic [511:0] wdataCap;
  logic [63:0]  beCap;
  logic [63:0]  addrLoad;
  logic         accept;
  logic         errSet;
  logic         timeoutHit;
  logic [5:0]   unusedAddrLsb;

  assign unusedAddrLsb = req_addr[5:0];
  assign accept = (state == IDLE) && req_ready && req_valid;

  // Address for the AW/AR payload register: fresh request on acceptance, else the captured line.
  always_comb begin
    addrLoad = addrCap;
    if (accept) addrLoad = {req_addr[63:6], 6'b0};
  end

`ifdef HAWK_AXI_LINE_TIMEOUT_EN
  logic [31:0] waitCnt;
  logic        inWait;

  assign inWait = (state == BWAIT) || (state == R0) || (state == R1);
  assign timeoutHit = inWait && (waitCnt == 32'(TIMEOUT_CYCLES - 1));

  // Watchdog: restarts on entry to BWAIT or R0 and runs through R1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
    end else if ((stateNext == BWAIT && state != BWAIT) || (stateNext == R0 && state != R0)) begin
      waitCnt <= '0;
    end else if (inWait) begin
      waitCnt <= waitCnt + 32'd1;
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_CYCLES;
  assign timeoutHit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state and error detection; a real handshake wins over a same-cycle timeout.
  always_comb begin
    stateNext = state;
    errSet    = 1'b0;
    case (state)
      IDLE:  if (accept) stateNext = req_wr ? AW : AR;
      AW:    if (awready) stateNext = W0;
      W0:    if (wready) stateNext = W1;
      W1:    if (wready) stateNext = BWAIT;
      BWAIT: begin
        if (bvalid) begin
          stateNext = RSP;
          errSet    = (bresp != 2'b00) || (bid != AXI_ID);
        end else if (timeoutHit) begin
          stateNext = RSP;
          errSet    = 1'b1;
        end
      end
      AR:    if (arready) stateNext = R0;
      R0: begin
        if (rvalid) begin
          stateNext = R1;
          errSet    = (rresp != 2'b00) || (rid != AXI_ID) || rlast;
        end else if (timeoutHit) begin
          stateNext = RSP;
          errSet    = 1'b1;
        end
      end
      R1: begin
        if (rvalid) begin
          stateNext = RSP;
          errSet    = (rresp != 2'b00) || (rid != AXI_ID) || !rlast;
        end else if (timeoutHit) begin
          stateNext = RSP;
          errSet    = 1'b1;
        end
      end
      RSP:   if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Request capture, read-data assembly and sticky error; cleared on return to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrCap   <= '0;
      wdataCap  <= '0;
      beCap     <= '0;
      rsp_wr    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      if (accept) begin
        addrCap  <= addrLoad;
        wdataCap <= req_wdata;
        beCap    <= req_be;
        rsp_wr   <= req_wr;
      end
      if (state == R0 && rvalid) rsp_rdata[255:0]   <= rdata;
      if (state == R1 && rvalid) rsp_rdata[511:256] <= rdata;
      if (errSet) rsp_err <= 1'b1;
      if (state == RSP && rsp_ready) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
    end
  end

  // Registered channel outputs, decoded from the upcoming state; payloads are zero when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      awlen     <= '0;
      awsize    <= '0;
      awburst   <= '0;
      awid      <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      arlen     <= '0;
      arsize    <= '0;
      arburst   <= '0;
      arid      <= '0;
      rready    <= 1'b0;
    end else begin
      req_ready <= (stateNext == IDLE);
      rsp_valid <= (stateNext == RSP);

      awvalid   <= (stateNext == AW);
      awaddr    <= (stateNext == AW) ? addrLoad : 64'd0;
      awlen     <= (stateNext == AW) ? 8'd1 : 8'd0;
      awsize    <= (stateNext == AW) ? 3'b101 : 3'b000;
      awburst   <= (stateNext == AW) ? 2'b01 : 2'b00;
      awid      <= (stateNext == AW) ? AXI_ID : 6'd0;

      wvalid    <= (stateNext == W0) || (stateNext == W1);
      wlast     <= (stateNext == W1);
      case (stateNext)
        W0: begin
          wdata <= wdataCap[255:0];
          wstrb <= beCap[31:0];
        end
        W1: begin
          wdata <= wdataCap[511:256];
          wstrb <= beCap[63:32];
        end
        default: begin
          wdata <= '0;
          wstrb <= '0;
        end
      endcase

      bready    <= (stateNext == BWAIT);

      arvalid   <= (stateNext == AR);
      araddr    <= (stateNext == AR) ? addrLoad : 64'd0;
      arlen     <= (stateNext == AR) ? 8'd1 : 8'd0;
      arsize    <= (stateNext == AR) ? 3'b101 : 3'b000;
      arburst   <= (stateNext == AR) ? 2'b01 : 2'b00;
      arid      <= (stateNext == AR) ? AXI_ID : 6'd0;

      rready    <= (stateNext == R0) || (stateNext == R1);
    end
  end

endmodule

// File: tb/tb_hawk_axi_line_master.sv
// Directed bench for hawk_axi_line_master: write/read lines, strobe pass-through,
// response errors, slave and core stalls, mid-transaction reset, and (with
// HAWK_AXI_LINE_TIMEOUT_EN) the response watchdog at TIMEOUT_CYCLES=16.
module tb_hawk_axi_line_master;

  logic         clk;
  logic         rst_n;
  logic         req_valid, req_ready, req_wr;
  logic [63:0]  req_addr;
  logic [511:0] req_wdata;
  logic [63:0]  req_be;
  logic         rsp_valid, rsp_ready, rsp_wr, rsp_err;
  logic [511:0] rsp_rdata;
  logic         awvalid, awready;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic [5:0]   awid;
  logic         wvalid, wready, wlast;
  logic [255:0] wdata;
  logic [31:0]  wstrb;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic [5:0]   bid;
  logic         arvalid, arready;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic [5:0]   arid;
  logic         rvalid, rready, rlast;
  logic [255:0] rdata;
  logic [1:0]   rresp;
  logic [5:0]   rid;

  int total = 0;
  int bad = 0;
  int rHs = 0;
  logic [511:0] memLine = '0;

  hawk_axi_line_master #(.AXI_ID(6'd0), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arid(arid),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .rid(rid), .rlast(rlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count read-data handshakes seen on the bus.
  always @(posedge clk) if (rvalid && rready) rHs <= rHs + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [63:0] a, input logic [511:0] d, input logic [63:0] be);
    int n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_be = be;
    step();
    req_valid = 1'b0;
    chk("req_ready_drop", req_ready, 0);
  endtask

  task automatic wr_line(input logic [63:0] a, input logic [511:0] d, input logic [63:0] be,
                         input logic [1:0] br, input logic [5:0] bi, input logic expErr,
                         input int stallAw, input int stallRsp);
    issue(1'b1, a, d, be);
    chk("aw_valid", awvalid, 1);
    chk("aw_addr", awaddr, a & ~64'h3f);
    chk("aw_len", awlen, 1);
    chk("aw_size", awsize, 3'b101);
    chk("aw_burst", awburst, 2'b01);
    chk("aw_id", awid, 0);
    chk("w_before_aw", wvalid, 0);
    for (int i = 0; i < stallAw; i++) begin
      step();
      chk("aw_hold_valid", awvalid, 1);
      chk("aw_hold_addr", awaddr, a & ~64'h3f);
      chk("aw_hold_wvalid", wvalid, 0);
      chk("aw_hold_req_ready", req_ready, 0);
    end
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("w0_valid", wvalid, 1);
    chk("w0_data", wdata, d[255:0]);
    chk("w0_strb", wstrb, be[31:0]);
    chk("w0_last", wlast, 0);
    memLine[255:0] = wdata;
    wready = 1'b1;
    step();
    chk("w1_valid", wvalid, 1);
    chk("w1_data", wdata, d[511:256]);
    chk("w1_strb", wstrb, be[63:32]);
    chk("w1_last", wlast, 1);
    memLine[511:256] = wdata;
    step();
    wready = 1'b0;
    chk("w_done", wvalid, 0);
    chk("b_ready", bready, 1);
    chk("b_early_rsp", rsp_valid, 0);
    bvalid = 1'b1; bresp = br; bid = bi;
    step();
    bvalid = 1'b0; bresp = 2'b00; bid = 6'd0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_wr", rsp_wr, 1);
    chk("wr_rsp_err", rsp_err, expErr);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    chk("b_ready_drop", bready, 0);
    for (int i = 0; i < stallRsp; i++) begin
      step();
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_req_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_next_ready", req_ready, 1);
  endtask

  task automatic rd_line(input logic [63:0] a, input logic [1:0] r0, input logic [1:0] r1,
                         input logic l0, input logic l1, input logic [5:0] ri,
                         input logic expErr, input logic [511:0] expData);
    int h0;
    issue(1'b0, a, '0, '0);
    h0 = rHs;
    chk("ar_valid", arvalid, 1);
    chk("ar_addr", araddr, a & ~64'h3f);
    chk("ar_len", arlen, 1);
    chk("ar_size", arsize, 3'b101);
    chk("ar_id", arid, 0);
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("r0_ready", rready, 1);
    rvalid = 1'b1; rdata = memLine[255:0]; rresp = r0; rlast = l0; rid = ri;
    step();
    chk("r1_ready", rready, 1);
    chk("r1_no_rsp", rsp_valid, 0);
    rdata = memLine[511:256]; rresp = r1; rlast = l1;
    step();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rid = 6'd0; rdata = '0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_wr", rsp_wr, 0);
    chk("rd_rsp_err", rsp_err, expErr);
    chk("rd_rsp_rdata", rsp_rdata, expData);
    chk("rd_handshakes", rHs - h0, 2);
    chk("r_ready_drop", rready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rd_rsp_done", rsp_valid, 0);
    chk("rd_err_clear", rsp_err, 0);
    chk("rd_data_clear", rsp_rdata, 0);
  endtask

  logic [511:0] dA, dB, dC;
  logic         noRsp;

  initial begin
    dA = {{32{8'h55}}, {32{8'hAA}}};
    dB = {8{64'h0123_4567_89AB_CDEF}};
    dC = {16{32'hDEAD_BEEF}};
    rst_n = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rid = '0; rlast = 1'b0;
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    rst_n = 1'b1;

    // Basic line write then read back.
    wr_line(64'h1040, dA, '1, 2'b00, 6'd0, 1'b0, 0, 0);
    rd_line(64'h1040, 2'b00, 2'b00, 1'b0, 1'b1, 6'd0, 1'b0, dA);

    // Partial strobes and an unaligned address that must be line-aligned.
    wr_line(64'h2075, dB, 64'h0000_0000_FFFF_0000, 2'b00, 6'd0, 1'b0, 0, 0);
    // SLVERR on read beat 1.
    rd_line(64'h2040, 2'b00, 2'b10, 1'b0, 1'b1, 6'd0, 1'b1, dB);

    // Wrong bid, then early rlast, then a clean read.
    wr_line(64'h3000, dC, '1, 2'b00, 6'd5, 1'b1, 0, 0);
    rd_line(64'h3000, 2'b00, 2'b00, 1'b1, 1'b1, 6'd0, 1'b1, dC);
    rd_line(64'h3000, 2'b00, 2'b00, 1'b0, 1'b1, 6'd0, 1'b0, dC);

    // Slave address stall and core response stall.
    wr_line(64'h4080, dA, '1, 2'b00, 6'd0, 1'b0, 20, 10);

    // Reset pulsed during W0 drops the transaction.
    issue(1'b1, 64'h5000, dB, '1);
    awready = 1'b1;
    step();
    awready = 1'b0;
    chk("mid_w0_valid", wvalid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_wvalid", wvalid, 0);
    chk("mid_rst_wdata", wdata, 0);
    chk("mid_rst_wstrb", wstrb, 0);
    chk("mid_rst_awvalid", awvalid, 0);
    chk("mid_rst_bready", bready, 0);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    step();
    rst_n = 1'b1;
    noRsp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (rsp_valid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) noRsp = 1'b0;
    end
    chk("mid_rst_no_rsp", noRsp, 1);
    rd_line(64'h4080, 2'b00, 2'b00, 1'b0, 1'b1, 6'd0, 1'b0, dA);

`ifdef HAWK_AXI_LINE_TIMEOUT_EN
    // Slave never answers B: abort 16 cycles after entering BWAIT.
    issue(1'b1, 64'h6000, dC, '1);
    awready = 1'b1;
    step();
    awready = 1'b0;
    wready = 1'b1;
    step();
    step();
    wready = 1'b0;
    chk("to_bready", bready, 1);
    for (int i = 0; i < 15; i++) step();
    chk("to_not_yet", rsp_valid, 0);
    chk("to_bready_late", bready, 1);
    step();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_bready_drop", bready, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("to_late_b_ignored", rsp_valid, 0);
    chk("to_late_b_bready", bready, 0);
    wr_line(64'h6000, dC, '1, 2'b00, 6'd0, 1'b0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
